mac_sequencer: RTL and testbench

Control front-end that drives one MAC unit through a full dot product. Operand pairs are accepted over a valid/ready stream into a small FIFO. The block then issues clear and enable strobes plus operands to the MAC, counts VEC_LEN accumulations, and returns the MAC's accumulated result over a valid/ready output stream. It sits between the operand-fetch logic and each MAC lane of the matrix-vector datapath.

---
 rtl/mac_sequencer_if.sv | 31 +++
 rtl/mac_sequencer.sv | 116 +++++++++++
 tb/tb_mac_sequencer.sv | 328 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mac_sequencer_if.sv
// Stream and MAC-lane handshake bundle for mac_sequencer.
// slave = the sequencer side, master = operand source / result sink / MAC side.
interface mac_sequencer_if #(
    parameter int DATA_WIDTH = 8
);
    logic                      start;
    logic                      busy;
    logic                      in_valid;
    logic                      in_ready;
    logic [DATA_WIDTH-1:0]     in_a;
    logic [DATA_WIDTH-1:0]     in_b;
    logic                      mac_en;
    logic                      mac_clr;
    logic [DATA_WIDTH-1:0]     mac_a;
    logic [DATA_WIDTH-1:0]     mac_b;
    logic [3*DATA_WIDTH-1:0]   mac_cout;
    logic                      res_valid;
    logic                      res_ready;
    logic [3*DATA_WIDTH-1:0]   res_data;
    logic                      done;

    modport slave (
        input  start, in_valid, in_a, in_b, mac_cout, res_ready,
        output busy, in_ready, mac_en, mac_clr, mac_a, mac_b, res_valid, res_data, done
    );

    modport master (
        output start, in_valid, in_a, in_b, mac_cout, res_ready,
        input  busy, in_ready, mac_en, mac_clr, mac_a, mac_b, res_valid, res_data, done
    );
endinterface

// File: rtl/mac_sequencer.sv
// Drives one MAC lane through a VEC_LEN-pair dot product fed from an operand FIFO.
// Optional `MAC_SEQ_ABORT_EN adds an abort input that returns any active job to IDLE.
module mac_sequencer #(
    parameter int DATA_WIDTH = 8,
    parameter int VEC_LEN    = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic           clk,
    input  logic           rst_n,
`ifdef MAC_SEQ_ABORT_EN
    input  logic           abort,
`endif
    mac_sequencer_if.slave bus
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int VC_W  = $clog2(VEC_LEN + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_RUN,
        S_CAPTURE,
        S_RESULT
    } state_t;

    state_t                state, state_nx;
    logic [DATA_WIDTH-1:0] mem_a [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] mem_b [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr, rd_ptr;
    logic [CNT_W-1:0]      fcount;
    logic [VC_W-1:0]       pair_cnt;
    logic                  full, empty, push, pop, last_pair;
    logic                  abort_go, abort_clr;

    assign full      = (fcount == CNT_W'(FIFO_DEPTH));
    assign empty     = (fcount == '0);
    assign push      = bus.in_valid && !full;
    assign last_pair = (pair_cnt == VC_W'(VEC_LEN - 1));

`ifdef MAC_SEQ_ABORT_EN
    assign abort_go = abort && (state != S_IDLE);
`else
    assign abort_go = 1'b0;
`endif

    // Storage needs no reset; occupancy is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_a[wr_ptr] <= bus.in_a;
            mem_b[wr_ptr] <= bus.in_b;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            fcount <= '0;
        end else if (abort_go) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            fcount <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            fcount <= fcount + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_comb begin
        state_nx = state;
        pop      = 1'b0;
        case (state)
            S_IDLE:    if (bus.start) state_nx = S_CLEAR;
            S_CLEAR:   state_nx = S_RUN;
            S_RUN: begin
                pop = !empty;
                if (pop && last_pair) state_nx = S_CAPTURE;
            end
            S_CAPTURE: state_nx = S_RESULT;
            S_RESULT:  if (bus.res_ready) state_nx = S_IDLE;
            default:   state_nx = S_IDLE;
        endcase
        if (abort_go) state_nx = S_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            pair_cnt     <= '0;
            abort_clr    <= 1'b0;
            bus.done     <= 1'b0;
            bus.res_data <= '0;
        end else begin
            state     <= state_nx;
            abort_clr <= abort_go;
            bus.done  <= (state == S_RESULT) && bus.res_ready && !abort_go;
            if (state == S_CLEAR)
                pair_cnt <= '0;
            else if (pop)
                pair_cnt <= pair_cnt + VC_W'(1);
            // The last enable landed on the previous edge, so mac_cout is final here.
            if (state == S_CAPTURE)
                bus.res_data <= bus.mac_cout;
        end
    end

    assign bus.busy      = (state != S_IDLE);
    assign bus.in_ready  = !full;
    assign bus.mac_en    = pop;
    assign bus.mac_clr   = (state == S_CLEAR) || abort_clr;
    assign bus.mac_a     = pop ? mem_a[rd_ptr] : '0;
    assign bus.mac_b     = pop ? mem_b[rd_ptr] : '0;
    assign bus.res_valid = (state == S_RESULT);
endmodule

// File: tb/tb_mac_sequencer.sv
// Bench for mac_sequencer: behavioural MAC, per-cycle scoreboard model, directed and random stimulus.
module tb_mac_sequencer;
    localparam int DW = 8;
    localparam int VL = 4;
    localparam int FD = 4;
    localparam logic [45:0] RST_OUTS = {1'b0, 1'b1, 1'b0, 1'b0, 8'h0, 8'h0, 1'b0, 24'h0, 1'b0};

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mac_sequencer_if #(.DATA_WIDTH(DW)) bus ();
`ifdef MAC_SEQ_ABORT_EN
    logic abort = 1'b0;
`endif

    mac_sequencer #(.DATA_WIDTH(DW), .VEC_LEN(VL), .FIFO_DEPTH(FD)) dut (
        .clk   (clk),
        .rst_n (rst_n),
`ifdef MAC_SEQ_ABORT_EN
        .abort (abort),
`endif
        .bus   (bus)
    );

    // Behavioural MAC lane
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)           bus.mac_cout <= '0;
        else if (bus.mac_clr) bus.mac_cout <= '0;
        else if (bus.mac_en)  bus.mac_cout <= bus.mac_cout + 24'(bus.mac_a) * 24'(bus.mac_b);
    end

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    function automatic logic [45:0] outs();
        return {bus.busy, bus.in_ready, bus.mac_en, bus.mac_clr, bus.mac_a, bus.mac_b,
                bus.res_valid, bus.res_data, bus.done};
    endfunction

    // Scoreboard model: FIFO as a queue, job progress as counts and latency flags.
    logic [15:0] q[$];
    bit     m_idle = 1, clr_due = 0, run_act = 0, cap_due = 0, res_exp = 0, done_exp = 0;
    int     pops = 0;
    longint acc = 0;

    always @(negedge clk) begin : model
        bit en_exp, pf, hs, st, ab, nxt_res;
        if (!rst_n) begin
            chk("reset_outputs", longint'(outs()), longint'(RST_OUTS));
            q.delete();
            m_idle = 1; clr_due = 0; run_act = 0; cap_due = 0; res_exp = 0; done_exp = 0;
            pops = 0; acc = 0;
        end else begin
            en_exp = run_act && (q.size() > 0);
            pf     = bus.in_valid && (q.size() < FD);
            chk("in_ready", longint'(bus.in_ready), longint'(q.size() < FD));
            chk("busy", longint'(bus.busy), longint'(!m_idle));
            chk("mac_clr", longint'(bus.mac_clr), longint'(clr_due));
            chk("mac_en", longint'(bus.mac_en), longint'(en_exp));
            if (en_exp) chk("mac_operands", longint'({bus.mac_a, bus.mac_b}), longint'(q[0]));
            else        chk("mac_operands_zero", longint'({bus.mac_a, bus.mac_b}), 0);
            chk("res_valid", longint'(bus.res_valid), longint'(res_exp));
            if (res_exp) chk("res_data", longint'(bus.res_data), acc);
            chk("done", longint'(bus.done), longint'(done_exp));

            hs = res_exp && bus.res_ready;
            st = bus.start && m_idle;
`ifdef MAC_SEQ_ABORT_EN
            ab = abort && !m_idle;
`else
            ab = 0;
`endif
            nxt_res = res_exp;
            if (cap_due) begin nxt_res = 1; cap_due = 0; end
            if (hs) nxt_res = 0;
            if (en_exp) begin
                acc += longint'(q[0][15:8]) * longint'(q[0][7:0]);
                pops++;
                void'(q.pop_front());
                if (pops == VL) begin run_act = 0; cap_due = 1; end
            end
            if (clr_due) begin run_act = 1; pops = 0; acc = 0; end
            if (pf) q.push_back({bus.in_a, bus.in_b});
            done_exp = hs;
            if (hs) m_idle = 1;
            if (st) m_idle = 0;
            clr_due = st;
            if (ab) begin
                q.delete();
                run_act = 0; cap_due = 0; nxt_res = 0; done_exp = 0; m_idle = 1; clr_due = 1;
            end
            res_exp = nxt_res;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] a, input logic [7:0] b);
        bit ok = 0;
        bus.in_valid = 1; bus.in_a = a; bus.in_b = b;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus.in_ready) begin ok = 1; break; end
            cyc();
        end
        if (!ok) chk("push_timeout", 0, 1);
        cyc();
        bus.in_valid = 0;
    endtask

    // Caller raises start beforehand if it wants a new job; returns after the done cycle.
    task automatic wait_result(input int restart_at, output longint res, output int first_a, output bit ok);
        bit seen_en = 0;
        res = -1; first_a = -1; ok = 0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (bus.mac_en && !seen_en) begin seen_en = 1; first_a = int'(bus.mac_a); end
            if (bus.res_valid) res = longint'(bus.res_data);
            ok = bus.done;
            cyc();
            bus.start = (c + 1 == restart_at);
            if (ok) break;
        end
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1);
    end

    initial begin : stim
        bit     hit, fin;
        longint got;
        int     fa, en_cnt, gaps, p, c_rdy, n, nd;
        logic [31:0] seq;

        bus.start = 0; bus.in_valid = 0; bus.in_a = 0; bus.in_b = 0; bus.res_ready = 1;
        #2 chk("reset_state", longint'(outs()), longint'(RST_OUTS));
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        cyc();

        // Basic dot product with cycle-exact timing
        for (int i = 0; i < 4; i++) push(8'(2*i+1), 8'(2*i+2));
        bus.start = 1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            case (c)
                1:          chk("basic_clr_c1", longint'(bus.mac_clr), 1);
                2, 3, 4, 5: chk("basic_en_c2_5", longint'(bus.mac_en), 1);
                6:          chk("basic_capture_c6", longint'({bus.mac_en, bus.res_valid}), 0);
                7: begin
                    chk("basic_valid_c7", longint'(bus.res_valid), 1);
                    chk("basic_res_c7", longint'(bus.res_data), 100);
                end
                8:          chk("basic_done_c8", longint'(bus.done), 1);
                9:          chk("basic_done_c9", longint'(bus.done), 0);
                default:    chk("basic_noclr_c0", longint'(bus.mac_clr), 0);
            endcase
            cyc();
            bus.start = 0;
        end

        // Starved input: one pair every third cycle
        bus.start = 1; cyc(); bus.start = 0;
        p = 0; en_cnt = 0; gaps = 0; got = -1; fin = 0;
        for (int k = 0; k < 80 && !fin; k++) begin
            if (k % 3 == 2 && p < 4) begin
                bus.in_valid = 1; bus.in_a = 8'(2*p+1); bus.in_b = 8'(2*p+2); p++;
            end else bus.in_valid = 0;
            @(negedge clk);
            if (bus.mac_en) en_cnt++;
            else if (en_cnt > 0 && en_cnt < 4) gaps++;
            if (bus.res_valid) got = longint'(bus.res_data);
            fin = bus.done;
            cyc();
        end
        bus.in_valid = 0;
        chk("starve_en_count", en_cnt, 4);
        chk("starve_gaps", gaps, 6);
        chk("starve_res", got, 100);
        chk("starve_done", longint'(fin), 1);

        // Result backpressure
        push(2, 3); push(4, 5); push(6, 7); push(8, 9);
        bus.res_ready = 0;
        bus.start = 1; cyc(); bus.start = 0;
        hit = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus.res_valid) begin hit = 1; break; end
            cyc();
        end
        chk("bp_valid_seen", longint'(hit), 1);
        for (int i = 0; i < 5; i++) begin
            chk("bp_hold_valid", longint'(bus.res_valid), 1);
            chk("bp_hold_data", longint'(bus.res_data), 140);
            cyc();
            if (i < 4) @(negedge clk);
        end
        bus.res_ready = 1;
        @(negedge clk);
        chk("bp_handshake", longint'({bus.res_valid, bus.done}), 2);
        cyc();
        nd = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (i == 0) chk("bp_done_next", longint'(bus.done), 1);
            nd += int'(bus.done);
            cyc();
        end
        chk("bp_done_once", nd, 1);

        // FIFO full: fifth pair waits for the first pop
        for (int i = 0; i < 4; i++) push(8'(10+i), 1);
        bus.in_valid = 1; bus.in_a = 14; bus.in_b = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("full_ready_low", longint'(bus.in_ready), 0);
            cyc();
        end
        bus.start = 1; c_rdy = -1; n = 0; seq = 0; got = -1; fin = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (bus.mac_en && n < 4) begin seq = {seq[23:0], bus.mac_a}; n++; end
            if (bus.in_ready && bus.in_valid && c_rdy < 0) c_rdy = c;
            if (bus.res_valid) got = longint'(bus.res_data);
            fin = bus.done;
            cyc();
            bus.start = 0;
            if (c_rdy >= 0) bus.in_valid = 0;
            if (fin) break;
        end
        bus.in_valid = 0;
        chk("full_ready_cycle", c_rdy, 3);
        chk("full_order", longint'(seq), 32'h0A0B0C0D);
        chk("full_res", got, 46);
        chk("full_done", longint'(fin), 1);
        push(15, 1); push(16, 1); push(17, 1);
        bus.start = 1;
        wait_result(-1, got, fa, fin);
        chk("full_fifth_first", fa, 14);
        chk("full_fifth_res", got, 62);
        chk("full_fifth_done", longint'(fin), 1);

        // Full-scale operands, start pulsed again during RUN
        for (int i = 0; i < 4; i++) push(255, 255);
        bus.start = 1;
        wait_result(3, got, fa, fin);
        chk("fullscale_res", got, 260100);
        chk("fullscale_done", longint'(fin), 1);
        @(negedge clk);
        chk("fullscale_no_restart", longint'({bus.busy, bus.mac_clr}), 0);
        cyc();

        // Asynchronous reset in the third RUN cycle
        for (int i = 0; i < 4; i++) push(2, 2);
        bus.start = 1; cyc(); bus.start = 0;
        cyc(); cyc(); cyc();
        rst_n = 0;
        #1 chk("reset_async", longint'(outs()), longint'(RST_OUTS));
        @(negedge clk);
        cyc();
        rst_n = 1;
        bus.start = 1; cyc(); bus.start = 0;
        en_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            en_cnt += int'(bus.mac_en);
            cyc();
        end
        chk("reset_fifo_empty", en_cnt, 0);
        for (int i = 0; i < 4; i++) push(1, 1);
        wait_result(-1, got, fa, fin);
        chk("reset_after_res", got, 4);
        chk("reset_after_done", longint'(fin), 1);

`ifdef MAC_SEQ_ABORT_EN
        // Abort in RUN: IDLE plus a clear pulse, FIFO flushed, no done
        for (int i = 0; i < 4; i++) push(3, 3);
        bus.start = 1; cyc(); bus.start = 0;
        cyc(); cyc();
        abort = 1; cyc(); abort = 0;
        @(negedge clk);
        chk("abort_state", longint'({bus.mac_clr, bus.busy, bus.in_ready, bus.res_valid}), 4'b1010);
        cyc();
        nd = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            nd += int'(bus.done);
            cyc();
        end
        chk("abort_no_done", nd, 0);
`endif

        // Randomised traffic against the scoreboard
        for (int i = 0; i < 3000; i++) begin
            bus.in_valid  = ($urandom_range(0, 1) == 1);
            bus.in_a      = 8'($urandom);
            bus.in_b      = 8'($urandom);
            bus.res_ready = ($urandom_range(0, 3) != 0);
            bus.start     = ($urandom_range(0, 7) == 0);
`ifdef MAC_SEQ_ABORT_EN
            abort         = ($urandom_range(0, 63) == 0);
`endif
            cyc();
        end
        bus.in_valid = 0; bus.start = 0; bus.res_ready = 1;
`ifdef MAC_SEQ_ABORT_EN
        abort = 0;
`endif
        repeat (20) cyc();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
